// File: rtl/gex_synaptic_accumulator_if.sv
// Handshake and result bundle between the gex accumulator and its neighbours.
// The slave modport is the accumulator side; the master modport is the driver side.
interface gex_synaptic_accumulator_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16
);
    logic                   Start;
    logic [DATA_WIDTH-1:0]  GexIn;
    logic                   EmptyList;
    logic                   WeightValid;
    logic [DATA_WIDTH-1:0]  Weight;
    logic                   WeightLast;
    logic                   WeightReady;
    logic [DATA_WIDTH-1:0]  GexOut;
    logic                   Done;
    logic                   Busy;
    logic                   Saturated;
    logic [COUNT_WIDTH-1:0] AcceptedCount;

    modport slave (
        input  Start, GexIn, EmptyList, WeightValid, Weight, WeightLast,
        output WeightReady, GexOut, Done, Busy, Saturated, AcceptedCount
    );

    modport master (
        output Start, GexIn, EmptyList, WeightValid, Weight, WeightLast,
        input  WeightReady, GexOut, Done, Busy, Saturated, AcceptedCount
    );
endinterface

// File: rtl/gex_synaptic_accumulator.sv
// Accumulates streamed synaptic weights onto one neuron's leaked gex with
// signed saturating fixed-point addition.
//
// state | meaning
// IDLE  | waiting for Start
// ACCUM | accepting weight beats until WeightLast
// DONE  | result held; Done pulses on first cycle; Start accepted again
module gex_synaptic_accumulator #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    gex_synaptic_accumulator_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0]  MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]  MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] CNT_FULL = {COUNT_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   done_q, done_d;

    logic [DATA_WIDTH:0]    sum_wide;
    logic                   sum_ovf;
    logic [DATA_WIDTH-1:0]  sum_clip;

    // One extra bit: the top two bits differ exactly when the signed add overflowed.
    assign sum_wide = {acc_q[DATA_WIDTH-1], acc_q} + {bus.Weight[DATA_WIDTH-1], bus.Weight};
    assign sum_ovf  = sum_wide[DATA_WIDTH] ^ sum_wide[DATA_WIDTH-1];
    assign sum_clip = sum_ovf ? (sum_wide[DATA_WIDTH] ? MIN_NEG : MAX_POS)
                              : sum_wide[DATA_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) begin
                    acc_d = bus.GexIn;
                    sat_d = 1'b0;
                    cnt_d = '0;
                    if (bus.EmptyList) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (bus.WeightValid) begin
                    acc_d = sum_clip;
                    if (sum_ovf) begin
                        sat_d = 1'b1;
                    end
                    if (cnt_q != CNT_FULL) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (bus.WeightLast) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.WeightReady   = (state_q == ST_ACCUM);
    assign bus.Busy          = (state_q == ST_ACCUM);
    assign bus.GexOut        = acc_q;
    assign bus.Done          = done_q;
    assign bus.Saturated     = sat_q;
    assign bus.AcceptedCount = cnt_q;

endmodule

// File: tb/tb_gex_synaptic_accumulator.sv
// Directed bench for gex_synaptic_accumulator with hand-computed expected values.
module tb_gex_synaptic_accumulator;

    localparam int DW = 64;
    localparam int CW = 16;

    localparam logic [63:0] G_1P0  = 64'h0000_0001_0000_0000;
    localparam logic [63:0] G_1P5  = 64'h0000_0001_8000_0000;
    localparam logic [63:0] G_1P75 = 64'h0000_0001_C000_0000;
    localparam logic [63:0] G_2P0  = 64'h0000_0002_0000_0000;
    localparam logic [63:0] G_3P25 = 64'h0000_0003_4000_0000;
    localparam logic [63:0] G_5P0  = 64'h0000_0005_0000_0000;
    localparam logic [63:0] W_0P25 = 64'h0000_0000_4000_0000;
    localparam logic [63:0] W_0P5  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] W_M2P0 = 64'hFFFF_FFFE_0000_0000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    gex_synaptic_accumulator_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    gex_synaptic_accumulator #(
        .INTEGER_WIDTH(32), .DATA_WIDTH_FRAC(32), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Start       = 1'b0;
        bus.GexIn       = '0;
        bus.EmptyList   = 1'b0;
        bus.WeightValid = 1'b0;
        bus.Weight      = '0;
        bus.WeightLast  = 1'b0;
    endtask

    task automatic start(input logic [63:0] gex, input logic empty);
        bus.Start     = 1'b1;
        bus.GexIn     = gex;
        bus.EmptyList = empty;
        tick();
        bus.Start     = 1'b0;
        bus.EmptyList = 1'b0;
    endtask

    task automatic beat(input logic [63:0] w, input logic last);
        bus.WeightValid = 1'b1;
        bus.Weight      = w;
        bus.WeightLast  = last;
        tick();
        bus.WeightValid = 1'b0;
        bus.WeightLast  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        rst_n = 1'b0;
        bus.WeightValid = 1'b1;
        tick();
        tick();
        chk("rst_ready",  {63'd0, bus.WeightReady}, 64'd0);
        chk("rst_gex",    bus.GexOut, 64'd0);
        chk("rst_done",   {63'd0, bus.Done}, 64'd0);
        chk("rst_busy",   {63'd0, bus.Busy}, 64'd0);
        chk("rst_sat",    {63'd0, bus.Saturated}, 64'd0);
        chk("rst_count",  {48'd0, bus.AcceptedCount}, 64'd0);
        bus.WeightValid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Empty list: result one cycle after Start
        start(G_2P0, 1'b1);
        chk("empty_done",  {63'd0, bus.Done}, 64'd1);
        chk("empty_gex",   bus.GexOut, G_2P0);
        chk("empty_count", {48'd0, bus.AcceptedCount}, 64'd0);
        chk("empty_busy",  {63'd0, bus.Busy}, 64'd0);
        tick();
        chk("empty_done_pulse", {63'd0, bus.Done}, 64'd0);
        chk("empty_gex_hold",   bus.GexOut, G_2P0);

        // Three back-to-back beats
        start(G_1P5, 1'b0);
        chk("b3_busy",  {63'd0, bus.Busy}, 64'd1);
        chk("b3_ready", {63'd0, bus.WeightReady}, 64'd1);
        chk("b3_load",  bus.GexOut, G_1P5);
        beat(W_0P25, 1'b0);
        chk("b3_partial", bus.GexOut, G_1P75);
        beat(W_0P5, 1'b0);
        beat(G_1P0, 1'b1);
        chk("b3_done",  {63'd0, bus.Done}, 64'd1);
        chk("b3_gex",   bus.GexOut, G_3P25);
        chk("b3_count", {48'd0, bus.AcceptedCount}, 64'd3);
        chk("b3_sat",   {63'd0, bus.Saturated}, 64'd0);
        chk("b3_ready_done", {63'd0, bus.WeightReady}, 64'd0);
        tick();
        chk("b3_done_pulse", {63'd0, bus.Done}, 64'd0);

        // Valid outside ACCUM must not transfer
        bus.WeightValid = 1'b1;
        bus.Weight      = G_5P0;
        bus.WeightLast  = 1'b1;
        tick();
        tick();
        bus.WeightValid = 1'b0;
        bus.WeightLast  = 1'b0;
        chk("oob_gex",   bus.GexOut, G_3P25);
        chk("oob_count", {48'd0, bus.AcceptedCount}, 64'd3);
        chk("oob_done",  {63'd0, bus.Done}, 64'd0);

        // Gaps between beats; idle cycles carry junk weight with Last
        start(G_1P5, 1'b0);
        beat(W_0P25, 1'b0);
        bus.Weight = G_5P0; bus.WeightLast = 1'b1; tick(); bus.WeightLast = 1'b0;
        beat(W_0P5, 1'b0);
        bus.Weight = G_5P0; bus.WeightLast = 1'b1; tick(); bus.WeightLast = 1'b0;
        chk("gap_busy", {63'd0, bus.Busy}, 64'd1);
        beat(G_1P0, 1'b1);
        chk("gap_done",  {63'd0, bus.Done}, 64'd1);
        chk("gap_gex",   bus.GexOut, G_3P25);
        chk("gap_count", {48'd0, bus.AcceptedCount}, 64'd3);
        tick();

        // Start during ACCUM is ignored
        start(G_1P5, 1'b0);
        beat(W_0P25, 1'b0);
        start(G_5P0, 1'b1);
        chk("ign_gex",  bus.GexOut, G_1P75);
        chk("ign_busy", {63'd0, bus.Busy}, 64'd1);
        beat(W_0P5, 1'b0);
        beat(G_1P0, 1'b1);
        chk("ign_final", bus.GexOut, G_3P25);
        chk("ign_count", {48'd0, bus.AcceptedCount}, 64'd3);

        // Positive saturation, then back-to-back neurons from the Done cycle
        tick();
        start(64'h7FFF_FFFF_0000_0000, 1'b0);
        beat(G_2P0, 1'b1);
        chk("psat_done",  {63'd0, bus.Done}, 64'd1);
        chk("psat_gex",   bus.GexOut, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("psat_flag",  {63'd0, bus.Saturated}, 64'd1);
        chk("psat_count", {48'd0, bus.AcceptedCount}, 64'd1);
        start(64'h8000_0001_0000_0000, 1'b0);
        chk("b2b_busy",  {63'd0, bus.Busy}, 64'd1);
        chk("b2b_sat",   {63'd0, bus.Saturated}, 64'd0);
        chk("b2b_count", {48'd0, bus.AcceptedCount}, 64'd0);
        chk("b2b_done",  {63'd0, bus.Done}, 64'd0);
        beat(W_M2P0, 1'b1);
        chk("nsat_done", {63'd0, bus.Done}, 64'd1);
        chk("nsat_gex",  bus.GexOut, 64'h8000_0000_0000_0000);
        chk("nsat_flag", {63'd0, bus.Saturated}, 64'd1);
        start(G_1P0, 1'b1);
        chk("b2b_empty_done", {63'd0, bus.Done}, 64'd1);
        chk("b2b_empty_gex",  bus.GexOut, G_1P0);
        chk("b2b_empty_sat",  {63'd0, bus.Saturated}, 64'd0);
        tick();

        // Reset in the middle of an update
        start(G_1P5, 1'b0);
        beat(W_0P25, 1'b0);
        bus.WeightValid = 1'b1;
        bus.Weight      = W_0P5;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, bus.WeightReady}, 64'd0);
        chk("mid_rst_gex",   bus.GexOut, 64'd0);
        chk("mid_rst_busy",  {63'd0, bus.Busy}, 64'd0);
        chk("mid_rst_count", {48'd0, bus.AcceptedCount}, 64'd0);
        tick();
        bus.WeightValid = 1'b0;
        rst_n = 1'b1;
        tick();
        start(G_2P0, 1'b1);
        chk("post_rst_done",  {63'd0, bus.Done}, 64'd1);
        chk("post_rst_gex",   bus.GexOut, G_2P0);
        chk("post_rst_count", {48'd0, bus.AcceptedCount}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gex_synaptic_accumulator.md
Name: gex_synaptic_accumulator

Overview:
- Sequential stage directly downstream of the excitatory-conductance leak stage.
- Takes one neuron's leaked gex, then adds the synaptic weight of every presynaptic spike streamed in for that neuron over a valid/ready handshake.
- Produces the updated gex for the membrane-update stage.
- Fixed-point format matches the leak stage: signed, INTEGER_WIDTH integer bits followed by DATA_WIDTH_FRAC fraction bits.

Parameters:
- INTEGER_WIDTH, 32, integer bits of the fixed-point format.
- DATA_WIDTH_FRAC, 32, fraction bits.
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, total word width.
- COUNT_WIDTH, 16, width of the accepted-weight counter.

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to begin a neuron update; sampled only in IDLE or DONE.
- GexIn  in  DATA_WIDTH  leaked gex, signed; captured when Start is accepted.
- EmptyList  in  1  qualifies Start: no spikes for this neuron.
- WeightValid  in  1  a weight beat is present.
- Weight  in  DATA_WIDTH  signed synaptic weight, same format as GexIn.
- WeightLast  in  1  qualifies a beat as the final one for this neuron.
- WeightReady  out  1  block can accept a beat.
- GexOut  out  DATA_WIDTH  accumulated gex; held stable in DONE.
- Done  out  1  one-cycle pulse when GexOut becomes valid.
- Busy  out  1  high in ACCUM.
- Saturated  out  1  sticky per update: some addition clipped.
- AcceptedCount  out  COUNT_WIDTH  beats accepted in the current or last update.

Behaviour:
- Reset (async, active-low) sets state to IDLE and clears GexOut, Done, Busy, Saturated, AcceptedCount and WeightReady to 0.
- On deassertion, the first active edge behaves as in IDLE.
- States: IDLE, ACCUM, DONE.
- IDLE or DONE with Start=1:
  - Load the accumulator with GexIn; clear Saturated and AcceptedCount.
  - If EmptyList=1, go to DONE. Done pulses next cycle and GexOut=GexIn (latency 1).
  - Otherwise go to ACCUM.
- ACCUM:
  - WeightReady=1 and Busy=1.
  - A beat transfers when WeightValid && WeightReady, one beat per cycle.
  - On transfer: accumulator <= sat(acc + Weight); AcceptedCount increments, saturating at all-ones (no wrap).
  - On a transfer with WeightLast=1, go to DONE. Done pulses the following cycle with GexOut equal to the final sum (one cycle after the last beat).
  - Start is ignored while in ACCUM.
- DONE:
  - WeightReady=0; GexOut, Saturated and AcceptedCount are held.
  - Done is high only on the first DONE cycle.
  - Start is accepted as in IDLE, so back-to-back neurons are possible.
- WeightValid outside ACCUM: no transfer, no state change.
- WeightLast with WeightValid=0: ignored.
- Arithmetic:
  - Full-width signed add in DATA_WIDTH+1 bits.
  - Positive overflow clips to the maximum positive value 0x7FFF…F.
  - Negative overflow clips to the minimum value 0x8000…0.
  - Any clip sets Saturated, which stays set until the next accepted Start.
- GexOut mirrors the accumulator register: registered, no combinational path from inputs.
- Reset mid-ACCUM aborts the update immediately; the partial sum is discarded.

Test Plan:
- Reset mid-run: Reset low with WeightValid=1 -> WeightReady=0, GexOut=0, IDLE. After release, Start with GexIn=0x0000_0002_0000_0000 and EmptyList=1 -> Done one cycle later, GexOut=2.0, AcceptedCount=0.
- Three-beat update:
  - Stimulus: Start with GexIn=1.5 (0x0000_0001_8000_0000); weights 0.25, 0.5, 1.0 back-to-back, Last on the third beat.
  - Response: Done 1 cycle after the third beat, GexOut=3.25 (0x0000_0003_4000_0000), AcceptedCount=3, Saturated=0.
- Backpressure gaps: same weights with WeightValid toggling 1,0,1,0,1 -> identical result; no beat lost or double-counted.
- Saturation:
  - Stimulus: GexIn=0x7FFF_FFFF_0000_0000, Weight=0x0000_0002_0000_0000 with Last.
  - Response: GexOut=0x7FFF_FFFF_FFFF_FFFF, Saturated=1.
  - Negative mirror: GexIn=0x8000_0001_0000_0000, Weight=-2.0 -> GexOut=0x8000_0000_0000_0000.
- Ignored Start: pulse Start with GexIn=5.0 during ACCUM -> accumulator unaffected, final result unchanged.
- Back-to-back neurons: Start asserted in the Done cycle with a new GexIn -> accepted. Saturated and AcceptedCount clear; the second result is independent of the first.
